serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port START  input  1  request to begin an operation; accepted only in IDLE.
REQ-005 The block SHALL have port A  input  WIDTH  operand A; sampled on the accepting edge only.
REQ-006 The block SHALL have port B  input  WIDTH  operand B; sampled on the accepting edge only.
REQ-007 The block SHALL have port CIN  input  1  carry-in (add) or borrow-in (subtract); sampled on the accepting edge.
REQ-008 The block SHALL have port SUB  input  1  0 = add, 1 = subtract; sampled on the accepting edge.
REQ-009 The block SHALL have port BUSY  output  1  high while bits are being processed.
REQ-010 The block SHALL have port DONE  output  1  one-cycle pulse marking SUM/COUT valid.
REQ-011 The block SHALL have port SUM  output  WIDTH  result, held stable between DONE pulses.
REQ-012 The block SHALL have port COUT  output  1  final carry out of the MSB, held with SUM.

Function
REQ-013 The block SHALL implement a three-state machine: IDLE, RUN, FIN.
REQ-014 IDLE with START=1 SHALL move to RUN and latch A, B XOR {WIDTH{SUB}}, and carry = CIN XOR SUB, and clear the bit counter.
REQ-015 IDLE with START=0 SHALL remain in IDLE.
REQ-016 RUN SHALL process exactly one bit per cycle, LSB first, through one full-adder slice, shifting the sum bit into an internal result register and registering the carry.
REQ-017 RUN SHALL last exactly WIDTH cycles, then move to FIN. Counter width: clog2(WIDTH+1).
REQ-018 On the RUN->FIN edge, SUM SHALL load the internal result and COUT the final carry; nowhere else SHALL they change except reset.
REQ-019 FIN SHALL assert DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-020 BUSY SHALL be 1 exactly while in RUN. A START accepted at edge k SHALL give BUSY for cycles k+1..k+WIDTH and DONE in cycle k+WIDTH+1.
REQ-021 START in RUN or FIN SHALL be ignored, with no queuing. Operand changes after acceptance SHALL have no effect.
REQ-022 Add mode SHALL produce {COUT,SUM} = A+B+CIN. Subtract mode SHALL produce SUM = (A-B-CIN) mod 2^WIDTH, with COUT=1 meaning no borrow.
REQ-023 Back-to-back operations SHALL be possible: START in the IDLE cycle right after FIN is accepted, giving a minimum issue interval of WIDTH+2 cycles.

Reset
REQ-024 RST_N=0 at a rising edge SHALL force IDLE and clear the counter, operand registers, carry, SUM, COUT, BUSY, DONE and OVF to 0, including mid-RUN (operation aborted, no DONE).
REQ-025 START asserted in the same cycle as RST_N=0 SHALL be ignored.

Configuration
REQ-026 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add port OVF  output  1: signed overflow = (carry into MSB) XOR (carry out of MSB), loaded and held with SUM.
REQ-027 Without SERIAL_ADDER_OVF_EN, port OVF and its logic SHALL be absent. All other behaviour SHALL be unchanged.

Structure
REQ-028 The shared package serial_adder_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and the default WIDTH constant.
REQ-029 The per-bit arithmetic SHALL be a sub-module named full_adder_slice (a, b, cin -> sum, cout), instantiated once.

Verification (WIDTH=8)
REQ-030 Add A=0x3C, B=0x21, CIN=0 -> SUM=0x5D, COUT=0, DONE exactly 9 cycles after the accepting edge, BUSY high for 8 cycles.
REQ-031 Add A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0. Add A=0x7F, B=0x01 -> SUM=0x80, COUT=0, OVF=1.
REQ-032 Sub A=0x20, B=0x10, CIN=0 -> SUM=0x10, COUT=1. Sub A=0x10, B=0x20, CIN=1 -> SUM=0xEF, COUT=0.
REQ-033 START pulsed in cycle 3 of RUN with different operands -> ignored, and the original result is delivered unchanged. START in the cycle after DONE -> accepted.
REQ-034 RST_N=0 for one cycle mid-RUN -> IDLE, all outputs 0, no DONE. A following add 0x01+0x02 -> SUM=0x03, COUT=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for serial_adder: FSM state encoding and default operand width.
package serial_adder_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFin  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_full_adder_slice.sv
// One-bit full adder used by serial_adder to process a single operand bit per cycle.
module full_adder_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit, LSB first, one bit per clock through a single full-adder slice.
// Optional signed-overflow output OVF is built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             SUB,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             OVF,
`endif
   output logic             COUT
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [CntW-1:0]  cnt_q;
   logic             carry_q;
   logic             bit_sum, bit_cout;
   logic             last_bit;

   full_adder_slice u_slice (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (bit_sum),
      .cout (bit_cout)
   );

   assign last_bit = (cnt_q == LastBit);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (START) state_d = StRun;
         StRun:   if (last_bit) state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      BUSY = (state_q == StRun);
      DONE = (state_q == StFin);
   end

   // Subtraction is A + ~B + ~borrow, so B and the carry are pre-inverted on acceptance.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         SUM     <= '0;
         COUT    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         OVF     <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  a_q     <= A;
                  b_q     <= B ^ {WIDTH{SUB}};
                  carry_q <= CIN ^ SUB;
                  cnt_q   <= '0;
               end
            end
            StRun: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               res_q   <= {bit_sum, res_q[WIDTH-1:1]};
               carry_q <= bit_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (last_bit) begin
                  SUM  <= {bit_sum, res_q[WIDTH-1:1]};
                  COUT <= bit_cout;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_q is the carry into the MSB during the final slice
                  OVF  <= carry_q ^ bit_cout;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 (OVF checks when SERIAL_ADDER_OVF_EN).
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         START;
   logic [W-1:0] A, B;
   logic         CIN, SUB;
   logic         BUSY, DONE, COUT;
   logic [W-1:0] SUM;
`ifdef SERIAL_ADDER_OVF_EN
   logic         OVF;
`endif

   int unsigned pass_cnt = 0;
   int unsigned total = 0;

   serial_adder #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .A     (A),
      .B     (B),
      .CIN   (CIN),
      .SUB   (SUB),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .SUM   (SUM),
`ifdef SERIAL_ADDER_OVF_EN
      .OVF   (OVF),
`endif
      .COUT  (COUT)
   );

   always #5 CLK = ~CLK;

   // Drive START for one cycle; returns at the negedge of the first RUN cycle.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      @(negedge CLK);
      A = a; B = b; CIN = cin; SUB = sub; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Counts cycles (current one = 1) until DONE; lat = 0 when the bound expires.
   task automatic wait_done(output int lat, output int busy);
      lat  = 0;
      busy = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (DONE) begin
            lat = cyc;
            break;
         end
         if (BUSY) busy++;
         @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      RST_N = 1'b0; START = 1'b1; A = 8'hFF; B = 8'hFF; CIN = 1'b1; SUB = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1; START = 1'b0;
      @(negedge CLK);
      total++;
      if ({BUSY, DONE, COUT, SUM} !== {3'b000, 8'h00})
         $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h want all 0",
                  BUSY, DONE, COUT, SUM);
      else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
      total++;
      if (OVF !== 1'b0) $display("FAIL reset_ovf: got %b want 0", OVF);
      else pass_cnt++;
`endif
   endtask

   task automatic test_add_basic;
      int lat, busy;
      issue(8'h3C, 8'h21, 1'b0, 1'b0);
      wait_done(lat, busy);
      total++;
      if (lat !== 9) $display("FAIL add_latency: got %0d want 9", lat);
      else pass_cnt++;
      total++;
      if (busy !== 8) $display("FAIL add_busy_cycles: got %0d want 8", busy);
      else pass_cnt++;
      total++;
      if ({COUT, SUM} !== {1'b0, 8'h5D})
         $display("FAIL add_3c_21: got cout=%b sum=%h want cout=0 sum=5d", COUT, SUM);
      else pass_cnt++;
      @(negedge CLK);
      total++;
      if ({DONE, BUSY} !== 2'b00)
         $display("FAIL done_one_cycle: got done=%b busy=%b want 0 0", DONE, BUSY);
      else pass_cnt++;
      total++;
      if (SUM !== 8'h5D) $display("FAIL sum_hold: got %h want 5d", SUM);
      else pass_cnt++;
   endtask

   task automatic test_add_carry;
      int lat, busy;
      issue(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_done(lat, busy);
      total++;
      if ({COUT, SUM} !== {1'b1, 8'h00})
         $display("FAIL add_ff_01: got cout=%b sum=%h want cout=1 sum=00", COUT, SUM);
      else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
      total++;
      if (OVF !== 1'b0) $display("FAIL ovf_ff_01: got %b want 0", OVF);
      else pass_cnt++;
`endif
      issue(8'h7F, 8'h01, 1'b0, 1'b0);
      wait_done(lat, busy);
      total++;
      if ({COUT, SUM} !== {1'b0, 8'h80})
         $display("FAIL add_7f_01: got cout=%b sum=%h want cout=0 sum=80", COUT, SUM);
      else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
      total++;
      if (OVF !== 1'b1) $display("FAIL ovf_7f_01: got %b want 1", OVF);
      else pass_cnt++;
`endif
   endtask

   task automatic test_sub;
      int lat, busy;
      issue(8'h20, 8'h10, 1'b0, 1'b1);
      wait_done(lat, busy);
      total++;
      if ({COUT, SUM} !== {1'b1, 8'h10})
         $display("FAIL sub_20_10: got cout=%b sum=%h want cout=1 sum=10", COUT, SUM);
      else pass_cnt++;
      issue(8'h10, 8'h20, 1'b1, 1'b1);
      wait_done(lat, busy);
      total++;
      if ({COUT, SUM} !== {1'b0, 8'hEF})
         $display("FAIL sub_10_20_b: got cout=%b sum=%h want cout=0 sum=ef", COUT, SUM);
      else pass_cnt++;
   endtask

   task automatic test_start_ignored;
      int lat, busy;
      issue(8'h55, 8'h11, 1'b0, 1'b0);
      repeat (2) @(negedge CLK);
      total++;
      if (SUM !== 8'hEF) $display("FAIL sum_stable_in_run: got %h want ef", SUM);
      else pass_cnt++;
      A = 8'hFF; B = 8'hFF; CIN = 1'b1; SUB = 1'b1; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_done(lat, busy);
      total++;
      if (lat !== 6) $display("FAIL ignored_start_latency: got %0d want 6", lat);
      else pass_cnt++;
      total++;
      if ({COUT, SUM} !== {1'b0, 8'h66})
         $display("FAIL ignored_start_result: got cout=%b sum=%h want cout=0 sum=66", COUT, SUM);
      else pass_cnt++;
   endtask

   // Called right after DONE: START in the very next (IDLE) cycle must be accepted.
   task automatic test_back_to_back;
      int lat, busy;
      issue(8'h10, 8'h20, 1'b1, 1'b0);
      wait_done(lat, busy);
      total++;
      if (lat !== 9) $display("FAIL b2b_latency: got %0d want 9", lat);
      else pass_cnt++;
      total++;
      if ({COUT, SUM} !== {1'b0, 8'h31})
         $display("FAIL b2b_result: got cout=%b sum=%h want cout=0 sum=31", COUT, SUM);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run;
      int lat, busy, dones;
      issue(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b0; START = 1'b1; A = 8'h0F; B = 8'h0F;
      @(negedge CLK);
      RST_N = 1'b1; START = 1'b0;
      total++;
      if ({BUSY, DONE, COUT, SUM} !== {3'b000, 8'h00})
         $display("FAIL mid_run_reset: got busy=%b done=%b cout=%b sum=%h want all 0",
                  BUSY, DONE, COUT, SUM);
      else pass_cnt++;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (DONE || BUSY) dones++;
         @(negedge CLK);
      end
      total++;
      if (dones !== 0) $display("FAIL no_done_after_reset: got %0d active cycles want 0", dones);
      else pass_cnt++;
      issue(8'h01, 8'h02, 1'b0, 1'b0);
      wait_done(lat, busy);
      total++;
      if ({COUT, SUM} !== {1'b0, 8'h03} || lat !== 9)
         $display("FAIL add_after_reset: got cout=%b sum=%h lat=%0d want cout=0 sum=03 lat=9",
                  COUT, SUM, lat);
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_add_basic;
      test_add_carry;
      test_sub;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid_run;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
